voice_allocator: RTL

Schedules note-on/note-off commands from the core onto the eight PWM channels, so software issues notes instead of managing channels directly. Holds the eight 16-bit PWM period registers, tracks which channels are sounding and how long each has been held, and steals the oldest voice when all eight are busy. Sits between the core's command interface and the eight `pwm` instances inside `synth_top`.

---
 rtl/voice_allocator.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
`timescale 1ns/1ps
// Maps note-on/off commands onto eight PWM period registers. Each command takes 10 cycles: IDLE, 8 SCAN, COMMIT.
// cmd_ready is high only in IDLE with all_off low. all_off clears every voice and aborts any command in flight.
module voice_allocator #(
    parameter int AGE_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_on,
    input  logic [6:0]  cmd_note,
    input  logic [15:0] cmd_period,
    input  logic        all_off,
    output logic [15:0] pwm_reg0,
    output logic [15:0] pwm_reg1,
    output logic [15:0] pwm_reg2,
    output logic [15:0] pwm_reg3,
    output logic [15:0] pwm_reg4,
    output logic [15:0] pwm_reg5,
    output logic [15:0] pwm_reg6,
    output logic [15:0] pwm_reg7,
    output logic [7:0]  voice_active,
    output logic        steal_pulse
);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    state_t state, state_nxt;

    logic [2:0]       idx;
    logic             lat_on;
    logic [6:0]       lat_note;
    logic [15:0]      lat_period;
    logic             match_found, free_found, old_found;
    logic [2:0]       match_idx, free_idx, old_idx;
    logic [AGE_W-1:0] old_age;

    logic [7:0]       active;
    logic [6:0]       note   [8];
    logic [15:0]      period [8];
    logic [AGE_W-1:0] age    [8];

    logic       xfer;
    logic [2:0] tgt;
    logic       steal;

    assign cmd_ready    = (state == IDLE) && !all_off;
    assign xfer         = cmd_valid && cmd_ready;
    assign voice_active = active;
    assign pwm_reg0 = period[0];
    assign pwm_reg1 = period[1];
    assign pwm_reg2 = period[2];
    assign pwm_reg3 = period[3];
    assign pwm_reg4 = period[4];
    assign pwm_reg5 = period[5];
    assign pwm_reg6 = period[6];
    assign pwm_reg7 = period[7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       state <= IDLE;
        else if (all_off) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = SCAN;
            SCAN:    if (idx == 3'd7) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Retrigger beats a free slot, which beats stealing the oldest voice.
    always_comb begin
        tgt   = match_idx;
        steal = 1'b0;
        if (lat_on && !match_found) begin
            if (free_found) begin
                tgt = free_idx;
            end else begin
                tgt   = old_idx;
                steal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            lat_on      <= 1'b0;
            lat_note    <= '0;
            lat_period  <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else if (state == IDLE && xfer) begin
            idx         <= '0;
            lat_on      <= cmd_on;
            lat_note    <= cmd_note;
            lat_period  <= cmd_period;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
        end else if (state == SCAN && !all_off) begin
            idx <= idx + 3'd1;
            if (active[idx] && note[idx] == lat_note && !match_found) begin
                match_found <= 1'b1;
                match_idx   <= idx;
            end
            if (!active[idx] && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= idx;
            end
            // Strictly-greater keeps the lower index on equal ages.
            if (active[idx] && (!old_found || age[idx] > old_age)) begin
                old_found <= 1'b1;
                old_idx   <= idx;
                old_age   <= age[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active      <= '0;
            steal_pulse <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                note[i]   <= '0;
                period[i] <= '0;
                age[i]    <= '0;
            end
        end else if (all_off) begin
            active      <= '0;
            steal_pulse <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                period[i] <= '0;
                age[i]    <= '0;
            end
        end else begin
            steal_pulse <= 1'b0;
            if (state == COMMIT) begin
                if (lat_on) begin
                    steal_pulse <= steal;
                    for (int i = 0; i < 8; i++) begin
                        if (3'(i) == tgt) begin
                            active[i] <= 1'b1;
                            note[i]   <= lat_note;
                            period[i] <= lat_period;
                            age[i]    <= '0;
                        end else if (active[i] && age[i] != AGE_MAX) begin
                            age[i] <= age[i] + 1'b1;
                        end
                    end
                end else if (match_found) begin
                    active[match_idx] <= 1'b0;
                    period[match_idx] <= '0;
                    age[match_idx]    <= '0;
                end
            end
        end
    end
endmodule
